// File: rtl/cmos_frame_capture_ctrl.sv
// cmos_frame_capture_ctrl
// Arms on command, aligns to a clean frame boundary, writes pixels into a
// ping-pong frame buffer, checks frame geometry and reports done/error.
module cmos_frame_capture_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              frame_vsync,
  input  logic              frame_href,
  input  logic              frame_clken,
  input  logic [7:0]        frame_data,
  input  logic              cap_start,
  input  logic              cap_stop,
  input  logic              cap_cont,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_buf,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  // Pixel index carries one extra bit so it can saturate at IMG_W*IMG_H
  // even when that equals 2^ADDR_W.
  localparam int               PIX_W    = ADDR_W + 1;
  localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(IMG_W * IMG_H);
  localparam logic [15:0]      COL_EXP  = 16'(IMG_W);
  localparam logic [15:0]      LINE_EXP = 16'(IMG_H);

  typedef enum logic [1:0] {IDLE, SYNC, WAIT_VS, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic              cont_q, cont_d;
  logic              vs_prev_q, href_prev_q;
  logic [PIX_W-1:0]  pix_idx_q, pix_idx_d;
  logic [15:0]       col_cnt_q, col_cnt_d;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic              buf_sel_q, buf_sel_d;
  logic              rd_buf_q, rd_buf_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              vs_rise, vs_fall, href_fall, pix_in;
  logic [15:0]       line_eff;
  logic              err_eff;

  assign vs_rise   = frame_vsync & ~vs_prev_q;
  assign vs_fall   = ~frame_vsync & vs_prev_q;
  assign href_fall = ~frame_href & href_prev_q;
  assign pix_in    = frame_href & frame_clken;

  // State register.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop always wins over start or a frame boundary.
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    case (state_q)
      IDLE: begin
        if (cap_start && !cap_stop) begin
          state_d = SYNC;
          cont_d  = cap_cont;
        end
      end
      SYNC: begin
        if (cap_stop)          state_d = IDLE;
        else if (!frame_vsync) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (cap_stop)     state_d = IDLE;
        else if (vs_rise) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cap_stop)     state_d = IDLE;
        else if (vs_fall) state_d = cont_q ? WAIT_VS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic: pixel writes, geometry check, buffer swap.
  // A line ending on the same cycle as the frame is folded into line_eff /
  // err_eff so the frame check sees it.
  always_comb begin
    pix_idx_d    = pix_idx_q;
    col_cnt_d    = col_cnt_q;
    line_cnt_d   = line_cnt_q;
    err_flag_d   = err_flag_q;
    buf_sel_d    = buf_sel_q;
    rd_buf_d     = rd_buf_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    line_eff     = line_cnt_q;
    err_eff      = err_flag_q;
    busy_d       = (state_d != IDLE);

    if (state_q == WAIT_VS && vs_rise && !cap_stop) begin
      pix_idx_d  = '0;
      col_cnt_d  = '0;
      line_cnt_d = '0;
      err_flag_d = 1'b0;
    end

    if (state_q == ACTIVE && !cap_stop) begin
      if (pix_in) begin
        if (col_cnt_q != '1) col_cnt_d = col_cnt_q + 1'b1;
        if (pix_idx_q < PIX_MAX) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {buf_sel_q, pix_idx_q[ADDR_W-1:0]};
          wr_data_d = frame_data;
          pix_idx_d = pix_idx_q + 1'b1;
        end
      end
      if (href_fall) begin
        col_cnt_d = '0;
        if (col_cnt_q != COL_EXP) err_eff = 1'b1;
        if (line_cnt_q != '1)     line_eff = line_cnt_q + 1'b1;
      end
      line_cnt_d = line_eff;
      err_flag_d = err_eff;
      if (vs_fall) begin
        if (err_eff || line_eff != LINE_EXP) begin
          frame_err_d = 1'b1;
        end else begin
          frame_done_d = 1'b1;
          rd_buf_d     = buf_sel_q;
          buf_sel_d    = ~buf_sel_q;
        end
      end
    end
  end

  // Datapath registers and edge-detect history.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q       <= 1'b0;
      vs_prev_q    <= 1'b0;
      href_prev_q  <= 1'b0;
      pix_idx_q    <= '0;
      col_cnt_q    <= '0;
      line_cnt_q   <= '0;
      err_flag_q   <= 1'b0;
      buf_sel_q    <= 1'b0;
      rd_buf_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      cont_q       <= cont_d;
      vs_prev_q    <= frame_vsync;
      href_prev_q  <= frame_href;
      pix_idx_q    <= pix_idx_d;
      col_cnt_q    <= col_cnt_d;
      line_cnt_q   <= line_cnt_d;
      err_flag_q   <= err_flag_d;
      buf_sel_q    <= buf_sel_d;
      rd_buf_q     <= rd_buf_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_buf     = rd_buf_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
